// File: rtl/req_queue3_pkg.sv
// req_queue3_pkg
//   Shared definitions for the three-channel request queue:
//   channel count, channel-index width, drop-counter width, and
//   grant decoding helpers.
package req_queue3_pkg;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned DROP_W = 8;

    // Index of the set bit of a one-hot vector; only meaningful when
    // the vector really is one-hot.
    function automatic logic [CH_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        onehot_to_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (oh[i]) onehot_to_idx = CH_W'(i);
        end
    endfunction

    function automatic logic is_onehot(input logic [NUM_CH-1:0] oh);
        is_onehot = (oh != '0) && ((oh & (oh - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/req_queue3_fifo.sv
// req_fifo
//   Single-channel FIFO of DEPTH entries (DEPTH a power of two, >= 2)
//   with wrapping pointers and an occupancy count 0..DEPTH.
//   Ports:
//     clk, asrst   clock, asynchronous active-high reset
//     push, wdata  write strobe and data (ignored when full)
//     pop          read strobe (ignored when empty)
//     rdata        head entry, combinational from registered state
//     full, empty  occupancy flags
module req_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          asrst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/req_queue3.sv
// req_queue3
//   Three independent request FIFOs feeding an external round-robin
//   arbiter. A one-hot grant pops the granted channel; the popped
//   payload and channel index are registered one cycle later.
//   Ports:
//     clk, asrst   clock, asynchronous active-high reset
//     en           enables request presentation and pops
//     in_vld/data  per-channel push strobe and payload (ch i at [i*DW +: DW])
//     in_rdy       per-channel not-full
//     req_vld      per-channel request (en & non-empty)
//     grant        one-hot grant from the arbiter
//     out_vld/data/ch  registered pop result
//     drop_cnt     per-channel saturating count of refused pushes
//   Build option: define REQ_QUEUE_DROP_CNT_EN to build the drop counters;
//   otherwise drop_cnt is tied to zero.
module req_queue3
    import req_queue3_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     asrst,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        in_vld,
    input  logic [NUM_CH*DW-1:0]     in_data,
    output logic [NUM_CH-1:0]        in_rdy,
    output logic [NUM_CH-1:0]        req_vld,
    input  logic [NUM_CH-1:0]        grant,
    output logic                     out_vld,
    output logic [DW-1:0]            out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic [NUM_CH*DROP_W-1:0] drop_cnt
);

    logic [DW-1:0]     rdata [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [DW-1:0]     pop_data;

    assign in_rdy  = ~full;
    assign req_vld = {NUM_CH{en}} & ~empty;
    assign push    = in_vld & in_rdy;
    assign pop     = is_onehot(grant) ? (grant & req_vld) : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .asrst (asrst),
            .push  (push[g]),
            .pop   (pop[g]),
            .wdata (in_data[g*DW +: DW]),
            .rdata (rdata[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    always_comb begin
        pop_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pop[i]) pop_data = rdata[i];
        end
    end

    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
        end else begin
            out_vld <= |pop;
            if (|pop) begin
                out_data <= pop_data;
                out_ch   <= onehot_to_idx(grant);
            end
        end
    end

`ifdef REQ_QUEUE_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q [NUM_CH];

    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) drop_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (in_vld[i] && !in_rdy[i] && (drop_q[i] != '1))
                    drop_q[i] <= drop_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) drop_cnt[i*DROP_W +: DROP_W] = drop_q[i];
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_req_queue3.sv
module tb_req_queue3;

    localparam int DEPTH = 4;
`ifdef REQ_QUEUE_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        asrst;
    logic        en;
    logic [2:0]  in_vld;
    logic [23:0] in_data;
    logic [2:0]  in_rdy;
    logic [2:0]  req_vld;
    logic [2:0]  grant;
    logic        out_vld;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic [23:0] drop_cnt;

    int checks = 0;
    int passed = 0;

    req_queue3 #(.DW(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .asrst    (asrst),
        .en       (en),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .req_vld  (req_vld),
        .grant    (grant),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_ch   (out_ch),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] q0[$], q1[$], q2[$];
    logic       exp_out_vld;
    logic [7:0] exp_out_data;
    logic [1:0] exp_out_ch;
    int         exp_drop [3];

    function automatic int qsize(int ch);
        case (ch)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [2:0] m_rdy();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (qsize(i) != DEPTH);
        return r;
    endfunction

    function automatic logic [2:0] m_req(logic e);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = e && (qsize(i) != 0);
        return r;
    endfunction

    function automatic logic [23:0] m_drop();
        logic [23:0] v;
        for (int i = 0; i < 3; i++) v[i*8 +: 8] = 8'(exp_drop[i]);
        return v;
    endfunction

    task automatic model_clear();
        q0.delete(); q1.delete(); q2.delete();
        exp_out_vld = 1'b0; exp_out_data = '0; exp_out_ch = '0;
        for (int i = 0; i < 3; i++) exp_drop[i] = 0;
    endtask

    task automatic drive(logic [2:0] v, logic [23:0] d, logic e, logic [2:0] g);
        in_vld = v; in_data = d; en = e; grant = g;
        #1;
    endtask

    // Advance one clock and move the model by the rules of the queue.
    task automatic tick();
        logic [2:0]  rdy, req, v;
        logic [23:0] d;
        logic [2:0]  g;
        rdy = m_rdy(); req = m_req(en);
        v = in_vld; d = in_data; g = grant;
        @(posedge clk); #1;
        exp_out_vld = 1'b0;
        if ($countones(g) == 1) begin
            for (int i = 0; i < 3; i++) begin
                if (g[i] && req[i]) begin
                    exp_out_vld = 1'b1;
                    exp_out_ch  = 2'(i);
                    case (i)
                        0:       exp_out_data = q0.pop_front();
                        1:       exp_out_data = q1.pop_front();
                        default: exp_out_data = q2.pop_front();
                    endcase
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                if (rdy[i]) begin
                    case (i)
                        0:       q0.push_back(d[7:0]);
                        1:       q1.push_back(d[15:8]);
                        default: q2.push_back(d[23:16]);
                    endcase
                end else if (DROP_EN && exp_drop[i] < 255) begin
                    exp_drop[i]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        drive(3'b000, 24'h0, 1'b0, 3'b000);
        asrst = 1'b1;
        model_clear();
        @(negedge clk);
        asrst = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        asrst = 1'b1;
        drive(3'b000, 24'h0, 1'b1, 3'b000);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld got %b want 0", out_vld); else passed++;
        checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data); else passed++;
        checks++; if (out_ch !== 2'd0) $display("FAIL reset_out_ch got %0d want 0", out_ch); else passed++;
        checks++; if (drop_cnt !== 24'h0) $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); else passed++;
        checks++; if (in_rdy !== 3'b111) $display("FAIL reset_in_rdy got %b want 111", in_rdy); else passed++;
        checks++; if (req_vld !== 3'b000) $display("FAIL reset_req_vld got %b want 000", req_vld); else passed++;
        @(negedge clk);
        asrst = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_vld !== 3'b000) $display("FAIL post_reset_req_vld got %b want 000", req_vld); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        drive(3'b001, 24'h0000A1, 1'b1, 3'b000);
        checks++; if (req_vld !== 3'b000) $display("FAIL basic_no_bypass got %b want 000", req_vld); else passed++;
        tick();
        drive(3'b000, 24'h0, 1'b1, 3'b001);
        checks++; if (req_vld !== 3'b001) $display("FAIL basic_req_vld got %b want 001", req_vld); else passed++;
        tick();
        checks++; if (out_vld !== 1'b1) $display("FAIL basic_out_vld got %b want 1", out_vld); else passed++;
        checks++; if (out_data !== 8'hA1) $display("FAIL basic_out_data got %h want a1", out_data); else passed++;
        checks++; if (out_ch !== 2'd0) $display("FAIL basic_out_ch got %0d want 0", out_ch); else passed++;
        checks++; if (req_vld !== 3'b000) $display("FAIL basic_req_after got %b want 000", req_vld); else passed++;
        drive(3'b000, 24'h0, 1'b1, 3'b001);
        tick();
        checks++; if (out_vld !== 1'b0) $display("FAIL basic_empty_grant got %b want 0", out_vld); else passed++;
        checks++; if (out_data !== 8'hA1) $display("FAIL basic_data_hold got %h want a1", out_data); else passed++;
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(3'b010, {8'h00, 8'(8'h10 + k), 8'h00}, 1'b0, 3'b000);
            tick();
        end
        checks++; if (in_rdy !== 3'b101) $display("FAIL full_in_rdy got %b want 101", in_rdy); else passed++;
        drive(3'b010, 24'h001400, 1'b0, 3'b000);
        tick();
        checks++; if (drop_cnt[15:8] !== (DROP_EN ? 8'd1 : 8'd0))
            $display("FAIL full_drop_cnt got %0d want %0d", drop_cnt[15:8], DROP_EN ? 1 : 0); else passed++;
        checks++; if (drop_cnt !== m_drop()) $display("FAIL full_drop_vec got %h want %h", drop_cnt, m_drop()); else passed++;
        for (int k = 0; k < 4; k++) begin
            drive(3'b000, 24'h0, 1'b1, 3'b010);
            tick();
            checks++; if (out_vld !== 1'b1 || out_data !== 8'(8'h10 + k) || out_ch !== 2'd1)
                $display("FAIL full_drain_%0d got vld=%b data=%h ch=%0d want 1 %h 1", k, out_vld, out_data, out_ch, 8'(8'h10 + k));
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h21, 8'h22, 8'h23, 8'h24};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(3'b100, {8'(8'h20 + k), 16'h0}, 1'b0, 3'b000);
            tick();
        end
        drive(3'b100, 24'h240000, 1'b1, 3'b100);
        checks++; if (in_rdy[2] !== 1'b0) $display("FAIL wrap_full_rdy got %b want 0", in_rdy[2]); else passed++;
        tick();
        checks++; if (out_vld !== 1'b1 || out_data !== 8'h20 || out_ch !== 2'd2)
            $display("FAIL wrap_first_pop got vld=%b data=%h ch=%0d want 1 20 2", out_vld, out_data, out_ch); else passed++;
        drive(3'b100, 24'h240000, 1'b1, 3'b100);
        checks++; if (in_rdy !== m_rdy()) $display("FAIL wrap_rdy got %b want %b", in_rdy, m_rdy()); else passed++;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_vld !== 1'b1 || out_data !== exp_seq[k] || out_ch !== 2'd2)
                $display("FAIL wrap_order_%0d got vld=%b data=%h ch=%0d want 1 %h 2", k, out_vld, out_data, out_ch, exp_seq[k]);
            else passed++;
            drive(3'b000, 24'h0, 1'b1, 3'b100);
        end
        checks++; if (req_vld !== 3'b000) $display("FAIL wrap_empty got %b want 000", req_vld); else passed++;
        checks++; if (drop_cnt !== m_drop()) $display("FAIL wrap_drop got %h want %h", drop_cnt, m_drop()); else passed++;
    endtask

    task automatic test_bad_grant();
        do_reset();
        drive(3'b011, 24'h003130, 1'b1, 3'b000);
        tick();
        drive(3'b000, 24'h0, 1'b1, 3'b011);
        tick();
        checks++; if (out_vld !== 1'b0) $display("FAIL multi_grant_out_vld got %b want 0", out_vld); else passed++;
        checks++; if (req_vld !== 3'b011) $display("FAIL multi_grant_req got %b want 011", req_vld); else passed++;
        drive(3'b000, 24'h0, 1'b1, 3'b111);
        tick();
        checks++; if (out_vld !== 1'b0) $display("FAIL all_grant_out_vld got %b want 0", out_vld); else passed++;
        drive(3'b000, 24'h0, 1'b1, 3'b010);
        tick();
        checks++; if (out_vld !== 1'b1 || out_data !== 8'h31 || out_ch !== 2'd1)
            $display("FAIL bad_grant_ch1 got vld=%b data=%h ch=%0d want 1 31 1", out_vld, out_data, out_ch); else passed++;
        drive(3'b000, 24'h0, 1'b1, 3'b001);
        tick();
        checks++; if (out_vld !== 1'b1 || out_data !== 8'h30 || out_ch !== 2'd0)
            $display("FAIL bad_grant_ch0 got vld=%b data=%h ch=%0d want 1 30 0", out_vld, out_data, out_ch); else passed++;
    endtask

    task automatic test_en_low();
        do_reset();
        drive(3'b111, 24'h424140, 1'b0, 3'b000);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 24'h0, 1'b0, 3'(1 << i));
            checks++; if (req_vld !== 3'b000) $display("FAIL en_low_req_%0d got %b want 000", i, req_vld); else passed++;
            tick();
            checks++; if (out_vld !== 1'b0) $display("FAIL en_low_out_vld_%0d got %b want 0", i, out_vld); else passed++;
        end
        drive(3'b000, 24'h0, 1'b1, 3'b000);
        checks++; if (req_vld !== 3'b111) $display("FAIL en_restore_req got %b want 111", req_vld); else passed++;
        for (int i = 2; i >= 0; i--) begin
            drive(3'b000, 24'h0, 1'b1, 3'(1 << i));
            tick();
            checks++; if (out_vld !== 1'b1 || out_data !== 8'(8'h40 + i) || out_ch !== 2'(i))
                $display("FAIL en_contents_%0d got vld=%b data=%h ch=%0d want 1 %h %0d", i, out_vld, out_data, out_ch, 8'(8'h40 + i), i);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(3'b001, {16'h0, 8'(8'h50 + k)}, 1'b0, 3'b000);
            tick();
        end
        drive(3'b000, 24'h0, 1'b1, 3'b001);
        tick();
        checks++; if (out_vld !== 1'b1 || out_data !== 8'h50)
            $display("FAIL arst_pre_pop got vld=%b data=%h want 1 50", out_vld, out_data); else passed++;
        #2 asrst = 1'b1;
        #1;
        model_clear();
        checks++; if (req_vld !== 3'b000) $display("FAIL arst_req_vld got %b want 000", req_vld); else passed++;
        checks++; if (in_rdy !== 3'b111) $display("FAIL arst_in_rdy got %b want 111", in_rdy); else passed++;
        checks++; if (out_vld !== 1'b0 || out_data !== 8'h00) $display("FAIL arst_out got vld=%b data=%h want 0 00", out_vld, out_data); else passed++;
        @(negedge clk);
        asrst = 1'b0;
        @(posedge clk); #1;
        drive(3'b000, 24'h0, 1'b1, 3'b001);
        checks++; if (req_vld !== 3'b000) $display("FAIL arst_after_req got %b want 000", req_vld); else passed++;
        tick();
        checks++; if (out_vld !== 1'b0) $display("FAIL arst_after_pop got %b want 0", out_vld); else passed++;
    endtask

    task automatic test_drop_saturate();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(3'b001, 24'h0000EE, 1'b0, 3'b000);
            tick();
        end
        repeat (260) tick();
        checks++; if (drop_cnt !== m_drop()) $display("FAIL drop_saturate got %h want %h", drop_cnt, m_drop()); else passed++;
    endtask

    task automatic test_random();
        logic [2:0] g;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       g = 3'($urandom_range(0, 7));
                default: g = 3'(1 << $urandom_range(0, 2));
            endcase
            drive(3'($urandom_range(0, 7)), 24'($urandom), ($urandom_range(0, 7) != 0), g);
            checks++; if (in_rdy !== m_rdy() || req_vld !== m_req(en))
                $display("FAIL rand_comb_%0d got rdy=%b req=%b want %b %b", n, in_rdy, req_vld, m_rdy(), m_req(en));
            else passed++;
            tick();
            checks++; if (out_vld !== exp_out_vld || out_data !== exp_out_data || out_ch !== exp_out_ch || drop_cnt !== m_drop())
                $display("FAIL rand_out_%0d got vld=%b data=%h ch=%0d drop=%h want %b %h %0d %h",
                         n, out_vld, out_data, out_ch, drop_cnt, exp_out_vld, exp_out_data, exp_out_ch, m_drop());
            else passed++;
        end
    endtask

    initial begin
        asrst = 1'b1;
        in_vld = '0; in_data = '0; en = 1'b0; grant = '0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_bad_grant();
        test_en_low();
        test_async_reset();
        test_drop_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
